regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port register file with an integrated busy-bit scoreboard, a same-cycle write-to-read bypass and optional hard-wired zero register. It is the next generation of the core's two-write-port register file, built for wider issue widths. It sits between issue and writeback: issue allocates destination registers, writeback writes them and clears their busy bits, and operand read returns data plus a busy flag per read port.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NRD, 2, number of read ports (1..8)
- NWR, 2, number of write ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- we  in  NWR  per-port write enable
- wa  in  NWR*ADDR_W  write addresses, port i at [i*ADDR_W +: ADDR_W]
- wd  in  NWR*DATA_W  write data, packed the same way
- ra  in  NRD*ADDR_W  read addresses
- rd  out  NRD*DATA_W  read data, combinational
- rbusy  out  NRD  busy flag of each read address, combinational
- alloc_v  in  1  issue requests allocation of alloc_a
- alloc_a  in  ADDR_W  destination to mark busy
- alloc_rdy  out  1  allocation is accepted this cycle
- wconf  out  1  registered flag: write-port address collision last cycle

## Operation
- Storage: DEPTH x DATA_W array plus a DEPTH-bit busy vector.
- Write: on each rising clk, each port with we[i]=1 writes wd[i] to wa[i]. If several ports hit the same address, the highest port index wins.
- With ZERO_REG=1, writes to address 0 are discarded.
- Write clears busy: any enabled write to address a clears busy[a] at the same edge.
- Allocation: alloc_rdy = !busy[alloc_a], or 1 when ZERO_REG=1 and alloc_a=0.
  - The handshake completes when alloc_v && alloc_rdy; it sets busy[alloc_a] at the edge.
  - Allocating address 0 with ZERO_REG=1 completes but sets nothing.
- Simultaneous events:
  - If busy[a]=1 and a write clears it this cycle, alloc_rdy for a stays 0. Reuse is possible from the next cycle.
  - If busy[a]=0 and an allocation and a write to a occur in the same cycle, the allocation wins: busy[a]=1 after the edge, and the write data is stored.
- Writes to non-busy registers are legal; data is stored and busy is unchanged.
- Read port j, evaluated in priority order:
  - ZERO_REG=1 and ra=0: rd=0, rbusy=0.
  - BYPASS=1 and some we[i] with wa[i]=ra: rd = highest-index matching wd, rbusy=0.
  - Otherwise: rd = array[ra], rbusy = busy[ra].
- wconf: registered 1 when two or more enabled write ports share a nonzero address (any address if ZERO_REG=0); otherwise 0.

## Timing
- Reset (rst_n low, asynchronous): all array entries 0, busy vector 0, wconf 0. Consequently rd=0, rbusy=0 and alloc_rdy=1 while reset is held.
- Reset asserted mid-operation discards in-flight allocations and writes of that cycle.
- The first write edge is the first rising clk after rst_n deasserts.
- Write-to-read latency:
  - BYPASS=1: 0 cycles.
  - BYPASS=0: 1 cycle, since data is visible after the edge.
- Allocate-to-busy latency: rbusy rises the cycle after the handshake.
- Writeback-to-not-busy:
  - BYPASS=1: same cycle, via the bypass.
  - BYPASS=0: next cycle.
- wconf is valid one cycle after the colliding writes and lasts one cycle.

## Structure
- Package regfile_pkg holds:
  - the default DATA_W/ADDR_W/NRD/NWR constants;
  - a function for the highest-index write match, returning hit and port index;
  - the port-slice helper for packed buses.
- Sub-module regfile_scoreboard holds the busy vector, alloc_rdy, busy set/clear and rbusy lookup. It is parametrised by ADDR_W, NRD, NWR and ZERO_REG.
- The top level holds the data array, the write-priority logic, the bypass muxes and the wconf register.

## Test plan
- Reset check: hold rst_n=0, drive ra={3,7} -> rd={0,0}, rbusy=0, alloc_rdy=1. Release reset and write port0 a=3 d=0xDEADBEEF -> next cycle rd[0]=0xDEADBEEF.
- Write collision: port0 a=5 d=0x11, port1 a=5 d=0x22 in the same cycle -> array[5]=0x22. wconf=1 for exactly the next cycle. Same collision on a=0 with ZERO_REG=1 -> wconf=0 and rd=0.
- Scoreboard: allocate a=9 -> alloc_rdy=1, then rbusy=1 next cycle and alloc_rdy=0 for a=9. Write a=9 d=0x55 -> BYPASS=1 gives rd=0x55, rbusy=0 the same cycle. Re-allocation of a=9 is accepted only from the following cycle.
- Same-cycle allocate and write to idle a=4 d=0x77 -> busy[4]=1 and array[4]=0x77 after the edge.
- BYPASS=0 build: write a=6 d=0xA5 while reading ra=6 -> old value that cycle, 0xA5 the next.
- Reset mid-operation: allocate a=12 and assert rst_n low before the clock edge -> busy[12]=0 and rd=0 for all addresses.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, match and slice helpers for regfile_sb
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NRD    = 2;
  localparam int DEF_NWR    = 2;

  // Upper bounds for the shared match helper; narrower instances zero-extend into them.
  localparam int MAX_NWR = 4;
  localparam int MAX_AW  = 16;
  localparam int IDX_W   = 2;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } wmatch_t;

  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

  // Later ports overwrite earlier hits, so the highest-index match is returned.
  function automatic wmatch_t wr_match(input logic [MAX_NWR-1:0]        we,
                                       input logic [MAX_NWR*MAX_AW-1:0] wa,
                                       input logic [MAX_AW-1:0]         a);
    wmatch_t m;
    m = '0;
    for (int i = 0; i < MAX_NWR; i++) begin
      if (we[i] && (wa[slice_lo(i, MAX_AW) +: MAX_AW] == a)) begin
        m.hit = 1'b1;
        m.idx = IDX_W'(i);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy-bit scoreboard: allocation handshake, writeback clear, per-port busy lookup
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = DEF_NRD,
  parameter int NWR      = DEF_NWR,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] wa,
  input  logic [NRD*ADDR_W-1:0] ra,
  input  logic                  alloc_v,
  input  logic [ADDR_W-1:0]     alloc_a,
  output logic                  alloc_rdy,
  output logic [NRD-1:0]        rbusy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             alloc_zero;

  assign alloc_zero = (ZERO_REG != 0) && (alloc_a == '0);
  // Looks at the registered busy bit only, so a same-cycle writeback cannot unblock reuse.
  assign alloc_rdy  = !busy[alloc_a] || alloc_zero;

  // Allocation is applied after the clears so it wins over a same-cycle write.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NWR; i++) begin
      if (we[i]) begin
        busy_nxt[wa[slice_lo(i, ADDR_W) +: ADDR_W]] = 1'b0;
      end
    end
    if (alloc_v && alloc_rdy && !alloc_zero) begin
      busy_nxt[alloc_a] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_comb begin
    rbusy = '0;
    for (int j = 0; j < NRD; j++) begin
      if (!((ZERO_REG != 0) && (ra[slice_lo(j, ADDR_W) +: ADDR_W] == '0))) begin
        rbusy[j] = busy[ra[slice_lo(j, ADDR_W) +: ADDR_W]];
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with busy scoreboard, write bypass and zero register
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = DEF_NRD,
  parameter int NWR      = DEF_NWR,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] wa,
  input  logic [NWR*DATA_W-1:0] wd,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rbusy,
  input  logic                  alloc_v,
  input  logic [ADDR_W-1:0]     alloc_a,
  output logic                  alloc_rdy,
  output logic                  wconf
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]         mem [DEPTH];
  logic [MAX_NWR-1:0]        we_x;
  logic [MAX_NWR*MAX_AW-1:0] wa_x;
  logic [NRD-1:0]            sb_rbusy;
  logic                      collide;

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .wa        (wa),
    .ra        (ra),
    .alloc_v   (alloc_v),
    .alloc_a   (alloc_a),
    .alloc_rdy (alloc_rdy),
    .rbusy     (sb_rbusy)
  );

  always_comb begin
    we_x = '0;
    wa_x = '0;
    for (int i = 0; i < NWR; i++) begin
      we_x[i] = we[i];
      wa_x[slice_lo(i, MAX_AW) +: MAX_AW] = MAX_AW'(wa[slice_lo(i, ADDR_W) +: ADDR_W]);
    end
  end

  // Ports are visited in ascending order, so the highest-index write to an address lands last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && !((ZERO_REG != 0) && (wa[slice_lo(i, ADDR_W) +: ADDR_W] == '0))) begin
          mem[wa[slice_lo(i, ADDR_W) +: ADDR_W]] <= wd[slice_lo(i, DATA_W) +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int k = i + 1; k < NWR; k++) begin
        if (we[i] && we[k] &&
            (wa[slice_lo(i, ADDR_W) +: ADDR_W] == wa[slice_lo(k, ADDR_W) +: ADDR_W]) &&
            !((ZERO_REG != 0) && (wa[slice_lo(i, ADDR_W) +: ADDR_W] == '0))) begin
          collide = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wconf <= 1'b0;
    end else begin
      wconf <= collide;
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              is_zero;
    logic              fwd_hit;
    wmatch_t           m;
    logic [DATA_W-1:0] fwd;

    assign a       = ra[slice_lo(j, ADDR_W) +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (a == '0);
    assign m       = wr_match(we_x, wa_x, MAX_AW'(a));
    assign fwd_hit = (BYPASS != 0) && m.hit;

    always_comb begin
      fwd = '0;
      for (int i = 0; i < NWR; i++) begin
        if (m.idx == IDX_W'(i)) begin
          fwd = wd[slice_lo(i, DATA_W) +: DATA_W];
        end
      end
    end

    assign rd[slice_lo(j, DATA_W) +: DATA_W] = is_zero ? '0 : (fwd_hit ? fwd : mem[a]);
    assign rbusy[j] = !is_zero && !fwd_hit && sb_rbusy[j];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb, BYPASS=1 and BYPASS=0 instances on shared stimulus
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic [9:0]  ra;
  logic        alloc_v;
  logic [4:0]  alloc_a;

  logic [63:0] rd_b, rd_n;
  logic [1:0]  rbusy_b, rbusy_n;
  logic        alloc_rdy_b, alloc_rdy_n;
  logic        wconf_b, wconf_n;

  int errors = 0;
  int checks = 0;

  int          sig_q[$];
  logic [31:0] val_q[$];
  string       tag_q[$];

  regfile_sb #(.BYPASS(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rd(rd_b), .rbusy(rbusy_b), .alloc_v(alloc_v), .alloc_a(alloc_a),
    .alloc_rdy(alloc_rdy_b), .wconf(wconf_b)
  );

  regfile_sb #(.BYPASS(0)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rd(rd_n), .rbusy(rbusy_n), .alloc_v(alloc_v), .alloc_a(alloc_a),
    .alloc_rdy(alloc_rdy_n), .wconf(wconf_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_RD0 = 0, S_RD1 = 1, S_BSY0 = 2, S_BSY1 = 3, S_RDY = 4, S_WCF = 5;
  localparam int S_NRD0 = 6, S_NBSY0 = 7, S_NRDY = 8, S_NWCF = 9;

  function automatic logic [31:0] obs(input int s);
    case (s)
      S_RD0:   return rd_b[31:0];
      S_RD1:   return rd_b[63:32];
      S_BSY0:  return {31'd0, rbusy_b[0]};
      S_BSY1:  return {31'd0, rbusy_b[1]};
      S_RDY:   return {31'd0, alloc_rdy_b};
      S_WCF:   return {31'd0, wconf_b};
      S_NRD0:  return rd_n[31:0];
      S_NBSY0: return {31'd0, rbusy_n[0]};
      S_NRDY:  return {31'd0, alloc_rdy_n};
      default: return {31'd0, wconf_n};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int s, input logic [31:0] v);
    tag_q.push_back(tag);
    sig_q.push_back(s);
    val_q.push_back(v);
  endtask

  task automatic drain();
    string       t;
    int          s;
    logic [31:0] v;
    while (sig_q.size() > 0) begin
      t = tag_q.pop_front();
      s = sig_q.pop_front();
      v = val_q.pop_front();
      check(t, obs(s), v);
    end
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    we[p] = 1'b1;
    wa[p*5 +: 5] = a;
    wd[p*32 +: 32] = d;
  endtask

  task automatic idle();
    we = '0;
    alloc_v = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; we = '0; wa = '0; wd = '0; alloc_v = 1'b0; alloc_a = '0;
    ra = {5'd7, 5'd3};
    #2;
    expect_val("rst_rd0", S_RD0, 0);
    expect_val("rst_rd1", S_RD1, 0);
    expect_val("rst_busy0", S_BSY0, 0);
    expect_val("rst_busy1", S_BSY1, 0);
    expect_val("rst_alloc_rdy", S_RDY, 1);
    expect_val("rst_wconf", S_WCF, 0);
    expect_val("rst_nb_rd0", S_NRD0, 0);
    settle();
    step();
    step();

    // First write after reset release
    rst_n = 1'b1;
    wr(0, 5'd3, 32'hDEADBEEF);
    expect_val("wr3_bypass", S_RD0, 32'hDEADBEEF);
    expect_val("wr3_bypass_busy", S_BSY0, 0);
    expect_val("wr3_nb_old", S_NRD0, 0);
    settle();
    step(); idle();
    expect_val("wr3_after", S_RD0, 32'hDEADBEEF);
    expect_val("wr3_nb_after", S_NRD0, 32'hDEADBEEF);
    settle();

    // Two ports to address 5: port 1 must win
    step();
    ra = {5'd5, 5'd5};
    wr(0, 5'd5, 32'h11); wr(1, 5'd5, 32'h22);
    expect_val("coll_bypass", S_RD0, 32'h22);
    expect_val("coll_wconf_early", S_WCF, 0);
    settle();
    step(); idle();
    expect_val("coll_wconf", S_WCF, 1);
    expect_val("coll_nb_wconf", S_NWCF, 1);
    expect_val("coll_mem", S_RD1, 32'h22);
    expect_val("coll_nb_mem", S_NRD0, 32'h22);
    settle();
    step();
    expect_val("coll_wconf_drop", S_WCF, 0);
    settle();

    // Collision on the zero register is ignored
    ra = {5'd5, 5'd0};
    wr(0, 5'd0, 32'h11); wr(1, 5'd0, 32'h22);
    expect_val("zero_bypass", S_RD0, 0);
    expect_val("zero_nb", S_NRD0, 0);
    settle();
    step(); idle();
    expect_val("zero_wconf", S_WCF, 0);
    expect_val("zero_rd", S_RD0, 0);
    expect_val("zero_busy", S_BSY0, 0);
    settle();

    // Allocate 9, write it back, then reallocate
    step();
    ra = {5'd0, 5'd9};
    alloc_v = 1'b1; alloc_a = 5'd9;
    expect_val("a9_rdy", S_RDY, 1);
    expect_val("a9_busy_pre", S_BSY0, 0);
    settle();
    step(); idle();
    expect_val("a9_busy", S_BSY0, 1);
    expect_val("a9_nb_busy", S_NBSY0, 1);
    expect_val("a9_rdy_blocked", S_RDY, 0);
    expect_val("a9_nb_rdy_blocked", S_NRDY, 0);
    settle();
    step();
    wr(0, 5'd9, 32'h55);
    alloc_v = 1'b1; alloc_a = 5'd9;
    expect_val("wb9_bypass", S_RD0, 32'h55);
    expect_val("wb9_bypass_busy", S_BSY0, 0);
    expect_val("wb9_rdy_still0", S_RDY, 0);
    expect_val("wb9_nb_busy", S_NBSY0, 1);
    expect_val("wb9_nb_old", S_NRD0, 0);
    settle();
    step();
    we = '0;
    expect_val("re9_rdy", S_RDY, 1);
    expect_val("re9_busy", S_BSY0, 0);
    expect_val("re9_rd", S_RD0, 32'h55);
    expect_val("re9_nb_rd", S_NRD0, 32'h55);
    expect_val("re9_nb_busy", S_NBSY0, 0);
    settle();
    step(); idle();
    expect_val("re9_busy_set", S_BSY0, 1);
    expect_val("re9_nb_busy_set", S_NBSY0, 1);
    settle();

    // Allocate and write idle register 4 in the same cycle
    step();
    ra = {5'd4, 5'd9};
    alloc_v = 1'b1; alloc_a = 5'd4;
    wr(0, 5'd4, 32'h77);
    expect_val("a4_rdy", S_RDY, 1);
    expect_val("a4_bypass", S_RD1, 32'h77);
    settle();
    step(); idle();
    expect_val("a4_busy", S_BSY1, 1);
    expect_val("a4_mem", S_RD1, 32'h77);
    settle();

    // Non-bypassed read sees the old value until the edge
    step();
    ra = {5'd4, 5'd6};
    wr(0, 5'd6, 32'hA5);
    expect_val("w6_nb_old", S_NRD0, 0);
    expect_val("w6_bypass", S_RD0, 32'hA5);
    settle();
    step(); idle();
    expect_val("w6_nb_new", S_NRD0, 32'hA5);
    settle();

    // Reset arrives before the edge that would complete allocation of 12
    step();
    ra = {5'd4, 5'd12};
    alloc_v = 1'b1; alloc_a = 5'd12;
    expect_val("a12_rdy", S_RDY, 1);
    settle();
    #1;
    rst_n = 1'b0;
    expect_val("mrst_rd4", S_RD1, 0);
    expect_val("mrst_busy4", S_BSY1, 0);
    expect_val("mrst_rdy", S_RDY, 1);
    settle();
    step();
    ra = {5'd6, 5'd3};
    expect_val("mrst_rd3", S_RD0, 0);
    expect_val("mrst_rd6", S_RD1, 0);
    settle();
    rst_n = 1'b1; idle();
    ra = {5'd4, 5'd12};
    step();
    expect_val("post_busy12", S_BSY0, 0);
    expect_val("post_nb_busy12", S_NBSY0, 0);
    expect_val("post_rd12", S_NRD0, 0);
    expect_val("post_wconf", S_WCF, 0);
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
